sp_bram_arb: RTL



---
 rtl/sp_bram_arb_pkg.sv | 14 +
 rtl/sp_bram_arb_if.sv | 27 ++
 rtl/sp_bram_arb_rr_arb2.sv | 19 +
 rtl/sp_bram_arb.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/sp_bram_arb_pkg.sv
// Shared types and constants for the two-requester single-port BRAM arbiter.
package sp_bram_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

  // Requester index, used for both the current grant and last_grant.
  typedef logic req_idx_t;

endpackage

// File: rtl/sp_bram_arb_if.sv
// Requester-side bundle: per-requester request handshake plus the shared response.
// The master side belongs to the requesters and the slave side to the arbiter.
interface sp_bram_arb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = 10
);
  import sp_bram_arb_pkg::*;

  logic [NUM_REQ-1:0]                 req_valid_i;
  logic [NUM_REQ-1:0]                 req_ready_o;
  logic [NUM_REQ-1:0]                 req_we_i;
  logic [NUM_REQ-1:0][ADDR_W-1:0]     req_addr_i;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata_i;
  logic [NUM_REQ-1:0]                 rsp_valid_o;
  logic [DATA_WIDTH-1:0]              rsp_rdata_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o
  );

endinterface

// File: rtl/sp_bram_arb_rr_arb2.sv
// Two-input round-robin picker, purely combinational.
// On a conflict the requester that did not win last time is chosen.
module rr_arb2
  import sp_bram_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  req_idx_t   last,
  output logic [1:0] grant
);

  // One-hot grant, or zero when nobody is asking.
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/sp_bram_arb.sv
// Round-robin arbiter and sequencer in front of one write-first single-port BRAM.
// Optional feature macro SP_BRAM_ARB_INIT_EN: clear the whole RAM after reset
// before any requester is served.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_INIT | zeroing sweep, one address per cycle, requesters held off
//   ST_RUN  | serving requesters, at most one access per cycle
module sp_bram_arb
  import sp_bram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SETS   = 1024,
  parameter int ADDR_W     = $clog2(NUM_SETS)
) (
  input  logic                  clk,
  input  logic                  rst,
  sp_bram_arb_if.slave          bus,
  output logic                  init_done_o,
  output logic                  bram_chip_en_o,
  output logic                  bram_wr_en_o,
  output logic [ADDR_W-1:0]     bram_addr_o,
  output logic [DATA_WIDTH-1:0] bram_wr_data_o,
  input  logic [DATA_WIDTH-1:0] bram_rd_data_i
);

`ifdef SP_BRAM_ARB_INIT_EN
  localparam arb_state_e RESET_STATE = ST_INIT;
`else
  localparam arb_state_e RESET_STATE = ST_RUN;
`endif

  arb_state_e         state, state_nxt;
  req_idx_t           last_grant;
  req_idx_t           grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic               xfer;

  rr_arb2 u_rr_arb2 (
    .valid (bus.req_valid_i),
    .last  (last_grant),
    .grant (grant)
  );

  assign grant_idx = grant[1];
  // Outputs read as reset values while rst is high, so nothing is accepted then.
  assign xfer      = !rst && (state == ST_RUN) && (grant != '0);

`ifdef SP_BRAM_ARB_INIT_EN
  // Counter is one bit wider than the address so non-power-of-two depths stop cleanly.
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(NUM_SETS - 1);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);
  logic [ADDR_W:0] init_cnt;

  // Sweep address counter, restarts from 0 on every reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      init_cnt <= init_cnt + CNT_ONE;
    end
  end

  assign init_done_o = !rst && (state == ST_RUN);
`else
  assign init_done_o = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET_STATE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: leave the sweep after the last address has been written.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: begin
`ifdef SP_BRAM_ARB_INIT_EN
        if (init_cnt == LAST_ADDR) state_nxt = ST_RUN;
`else
        state_nxt = ST_RUN;
`endif
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Outputs: sweep writes in ST_INIT, granted requester's fields in ST_RUN.
  always_comb begin
    bus.req_ready_o = '0;
    bram_chip_en_o  = 1'b0;
    bram_wr_en_o    = 1'b0;
    bram_addr_o     = '0;
    bram_wr_data_o  = '0;
    if (!rst) begin
      case (state)
        ST_INIT: begin
`ifdef SP_BRAM_ARB_INIT_EN
          bram_chip_en_o = 1'b1;
          bram_wr_en_o   = 1'b1;
          bram_addr_o    = init_cnt[ADDR_W-1:0];
`endif
        end
        default: begin
          if (xfer) begin
            bus.req_ready_o = grant;
            bram_chip_en_o  = 1'b1;
            bram_wr_en_o    = bus.req_we_i[grant_idx];
            bram_addr_o     = bus.req_addr_i[grant_idx];
            bram_wr_data_o  = bus.req_wdata_i[grant_idx];
          end
        end
      endcase
    end
  end

  // Round-robin history moves only on an accepted transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (xfer) begin
      last_grant <= grant_idx;
    end
  end

  // Response steering: remember who owns the RAM data arriving next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= '0;
    end else begin
      rsp_valid_q <= xfer ? grant : '0;
    end
  end

  // A response still in flight when reset rises is dropped immediately.
  assign bus.rsp_valid_o = rst ? '0 : rsp_valid_q;
  assign bus.rsp_rdata_o = (bus.rsp_valid_o != '0) ? bram_rd_data_i : '0;

endmodule
